// File: rtl/matrix_frame_capture_if.sv
// Matrix serial-drive pins plus the frame read port, shared by the driver side (master)
// and the capture block (slave).
interface matrix_frame_capture_if #(
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int FCNT_W = 8
);
  localparam int RW = $clog2(ROWS);

  logic              cclk;
  logic              csdi;
  logic              le;
  logic              rclk;
  logic              rsdi;
  logic              oeb;
  logic [RW-1:0]     rd_row;
  logic [COLS-1:0]   rd_data;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_count;
  logic              err;
  logic [FCNT_W-1:0] err_count;

  modport master (
    output cclk, csdi, le, rclk, rsdi, oeb, rd_row,
    input  rd_data, frame_done, frame_count, err, err_count
  );

  modport slave (
    input  cclk, csdi, le, rclk, rsdi, oeb, rd_row,
    output rd_data, frame_done, frame_count, err, err_count
  );
endinterface

// File: rtl/matrix_frame_capture.sv
// Receive-side model of the LED matrix serial drive: rebuilds rows into a double-buffered frame store.
// Define INPUT_SYNC_EN to put a two-flop synchroniser on the six matrix pins (event latency 3 instead of 1).
module matrix_frame_capture #(
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int FCNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_frame_capture_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  // Pin vector order {oeb, rsdi, rclk, le, csdi, cclk}; idle has oeb high.
  localparam logic [5:0] PIN_IDLE = 6'b100000;

  typedef enum logic {FILLING, SWAP} state_e;

  logic [5:0] rawPins;
  logic [5:0] pins;

  assign rawPins = {bus.oeb, bus.rsdi, bus.rclk, bus.le, bus.csdi, bus.cclk};

`ifdef INPUT_SYNC_EN
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= rawPins;
      sync2_q <= sync1_q;
    end
  end

  assign pins = sync2_q;
`else
  assign pins = rawPins;
`endif

  logic [3:0]        prev_q;
  logic [COLS-1:0]   colSr_q, colSr_d;
  logic [COLS-1:0]   colLat_q, colLat_d;
  logic [ROWS-1:0]   rowSr_q, rowSr_d;
  logic [ROWS-1:0]   rowMask_q, rowMask_d;
  logic [ROWS-1:0]   maskMerged;
  logic              capSel_q, capSel_d;
  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [FCNT_W-1:0] errCount_q, errCount_d;
  logic [FCNT_W-1:0] frameCount_q, frameCount_d;
  logic [COLS-1:0]   rdData_q;
  logic [COLS-1:0]   buf_q [2][ROWS];

  logic              cclkRise, leRise, rclkRise, oebFall;
  logic              rowOneHot;
  logic              wrEn;
  logic [RW-1:0]     wrIdx;

  assign cclkRise  = pins[0] & ~prev_q[0];
  assign leRise    = pins[2] & ~prev_q[1];
  assign rclkRise  = pins[3] & ~prev_q[2];
  assign oebFall   = ~pins[5] & prev_q[3];
  assign rowOneHot = (rowSr_q != '0) && ((rowSr_q & (rowSr_q - 1'b1)) == '0);
  assign maskMerged = rowMask_q | rowSr_q;

  always_comb begin
    wrIdx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (rowSr_q[i]) wrIdx = RW'(i);
    end
  end

  // Latch and commit always see the pre-event shift registers, so same-cycle edges use old data.
  always_comb begin
    colSr_d      = colSr_q;
    colLat_d     = colLat_q;
    rowSr_d      = rowSr_q;
    rowMask_d    = rowMask_q;
    capSel_d     = capSel_q;
    state_d      = FILLING;
    err_d        = 1'b0;
    errCount_d   = errCount_q;
    frameCount_d = frameCount_q;
    wrEn         = 1'b0;

    if (cclkRise) colSr_d = {colSr_q[COLS-2:0], pins[1]};
    if (leRise)   colLat_d = colSr_q;
    if (rclkRise) rowSr_d = {rowSr_q[ROWS-2:0], pins[4]};

    if (oebFall) begin
      if (rowOneHot) begin
        wrEn      = 1'b1;
        rowMask_d = maskMerged;
        if (&maskMerged) begin
          rowMask_d    = '0;
          capSel_d     = ~capSel_q;
          state_d      = SWAP;
          frameCount_d = frameCount_q + 1'b1;
        end
      end else begin
        err_d = 1'b1;
        if (~&errCount_q) errCount_d = errCount_q + 1'b1;
      end
    end
  end

  // Reads use the pre-swap display select, so a new frame shows from the following read on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= 4'b1000;
      colSr_q      <= '0;
      colLat_q     <= '0;
      rowSr_q      <= '0;
      rowMask_q    <= '0;
      capSel_q     <= 1'b0;
      state_q      <= FILLING;
      err_q        <= 1'b0;
      errCount_q   <= '0;
      frameCount_q <= '0;
      rdData_q     <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          buf_q[b][r] <= '0;
        end
      end
    end else begin
      prev_q       <= {pins[5], pins[3], pins[2], pins[0]};
      colSr_q      <= colSr_d;
      colLat_q     <= colLat_d;
      rowSr_q      <= rowSr_d;
      rowMask_q    <= rowMask_d;
      capSel_q     <= capSel_d;
      state_q      <= state_d;
      err_q        <= err_d;
      errCount_q   <= errCount_d;
      frameCount_q <= frameCount_d;
      if (wrEn) buf_q[capSel_q][wrIdx] <= colLat_q;
      rdData_q     <= buf_q[~capSel_q][bus.rd_row];
    end
  end

  assign bus.rd_data     = rdData_q;
  assign bus.frame_done  = (state_q == SWAP);
  assign bus.frame_count = frameCount_q;
  assign bus.err         = err_q;
  assign bus.err_count   = errCount_q;
endmodule

// File: tb/tb_matrix_frame_capture.sv
// Self-checking bench for matrix_frame_capture: a frame-level reference model is checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_matrix_frame_capture;
  localparam int COLS   = 16;
  localparam int ROWS   = 16;
  localparam int FCNT_W = 8;
  localparam int RW     = $clog2(ROWS);
`ifdef INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  // Pin vector order {oeb, rsdi, rclk, le, csdi, cclk}.
  localparam logic [5:0] PIN_IDLE = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  matrix_frame_capture_if #(.COLS(COLS), .ROWS(ROWS), .FCNT_W(FCNT_W)) mIf ();

  matrix_frame_capture #(.COLS(COLS), .ROWS(ROWS), .FCNT_W(FCNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mIf)
  );

  int compared   = 0;
  int mismatched = 0;
  int donePulses = 0;
  int errPulses  = 0;

  logic [COLS-1:0]   mCap  [ROWS];
  logic [COLS-1:0]   mDisp [ROWS];
  logic [COLS-1:0]   mColSr, mColLat;
  logic [ROWS-1:0]   mRowSr, mSeen;
  logic [FCNT_W-1:0] mFrames, mErrs;
  logic [COLS-1:0]   expRd;
  logic              expDone, expErr;
  logic [5:0]        hist[$];
  logic [5:0]        pinsNow;
  logic              randRd  = 1'b0;
  logic              checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < ROWS; r++) begin
      mCap[r]  = '0;
      mDisp[r] = '0;
    end
    mColSr  = '0;
    mColLat = '0;
    mRowSr  = '0;
    mSeen   = '0;
    mFrames = '0;
    mErrs   = '0;
    expRd   = '0;
    expDone = 1'b0;
    expErr  = 1'b0;
    hist.delete();
    repeat (LAT) hist.push_back(PIN_IDLE);
  endtask

  // One clock edge of the reference: the pins seen LAT-1 edges ago act now.
  task automatic modelEdge(input logic [RW-1:0] rdRowUsed);
    logic [5:0]      cur, prev;
    logic [COLS-1:0] oldColSr, oldColLat, tmp;
    logic [ROWS-1:0] oldRowSr;
    expRd   = mDisp[rdRowUsed];
    expDone = 1'b0;
    expErr  = 1'b0;
    hist.push_back(pinsNow);
    cur  = hist[1];
    prev = hist[0];
    void'(hist.pop_front());
    oldColSr  = mColSr;
    oldColLat = mColLat;
    oldRowSr  = mRowSr;
    if (cur[0] && !prev[0]) mColSr = {oldColSr[COLS-2:0], cur[1]};
    if (cur[2] && !prev[2]) mColLat = oldColSr;
    if (cur[3] && !prev[3]) mRowSr = {oldRowSr[ROWS-2:0], cur[4]};
    if (!cur[5] && prev[5]) begin
      if ($countones(oldRowSr) == 1) begin
        for (int r = 0; r < ROWS; r++) begin
          if (oldRowSr[r]) begin
            mCap[r]  = oldColLat;
            mSeen[r] = 1'b1;
          end
        end
        if (&mSeen) begin
          for (int r = 0; r < ROWS; r++) begin
            tmp      = mDisp[r];
            mDisp[r] = mCap[r];
            mCap[r]  = tmp;
          end
          mSeen   = '0;
          mFrames = mFrames + 1'b1;
          expDone = 1'b1;
        end
      end else begin
        expErr = 1'b1;
        if (mErrs != '1) mErrs = mErrs + 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [5:0] p);
    logic [RW-1:0] rr;
    pinsNow = p;
    if (randRd) mIf.rd_row = RW'($urandom_range(0, ROWS - 1));
    {mIf.oeb, mIf.rsdi, mIf.rclk, mIf.le, mIf.csdi, mIf.cclk} = p;
    rr = mIf.rd_row;
    @(posedge clk);
    #1;
    modelEdge(rr);
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("rd_data", 32'(mIf.rd_data), 32'(expRd));
        checkOutput("frame_done", 32'(mIf.frame_done), 32'(expDone));
        checkOutput("frame_count", 32'(mIf.frame_count), 32'(mFrames));
        checkOutput("err", 32'(mIf.err), 32'(expErr));
        checkOutput("err_count", 32'(mIf.err_count), 32'(mErrs));
        if (mIf.frame_done === 1'b1) donePulses++;
        if (mIf.err === 1'b1) errPulses++;
      end
    end
  endtask

  task automatic resetDut();
    checkEn = 1'b0;
    reset   = 1'b1;
    pinsNow = PIN_IDLE;
    {mIf.oeb, mIf.rsdi, mIf.rclk, mIf.le, mIf.csdi, mIf.cclk} = PIN_IDLE;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkEn = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(PIN_IDLE);
  endtask

  task automatic shiftCol(input logic [COLS-1:0] w);
    for (int b = COLS - 1; b >= 0; b--) begin
      applyStimulus({4'b1000, w[b], 1'b0});
      applyStimulus({4'b1000, w[b], 1'b1});
    end
    applyStimulus(PIN_IDLE);
  endtask

  task automatic shiftRow(input logic [ROWS-1:0] w);
    for (int b = ROWS - 1; b >= 0; b--) begin
      applyStimulus({1'b1, w[b], 1'b0, 3'b000});
      applyStimulus({1'b1, w[b], 1'b1, 3'b000});
    end
    applyStimulus(PIN_IDLE);
  endtask

  task automatic pulseLe();
    applyStimulus(6'b100100);
    applyStimulus(PIN_IDLE);
  endtask

  task automatic pulseOeb();
    applyStimulus(6'b000000);
    applyStimulus(PIN_IDLE);
  endtask

  task automatic commitSel(input logic [ROWS-1:0] sel, input logic [COLS-1:0] data);
    shiftCol(data);
    pulseLe();
    shiftRow(sel);
    pulseOeb();
  endtask

  task automatic commitRow(input int r, input logic [COLS-1:0] data);
    commitSel(ROWS'(1) << r, data);
  endtask

  task automatic readRow(input int r, input logic [COLS-1:0] want, input string name);
    mIf.rd_row = RW'(r);
    idle(LAT + 1);
    checkOutput(name, 32'(mIf.rd_data), 32'(want));
  endtask

  initial begin
    int d0, e0, r;
    logic [ROWS-1:0] sel;
    logic rs;
    mIf.rd_row = '0;
    {mIf.oeb, mIf.rsdi, mIf.rclk, mIf.le, mIf.csdi, mIf.cclk} = PIN_IDLE;
    pinsNow = PIN_IDLE;
    modelReset();
    fork
      compareLoop();
    join_none

    // Scenario 1: single row capture, nothing displayed yet.
    resetDut();
    checkOutput("reset_frame_count", 32'(mIf.frame_count), 32'h0);
    checkOutput("reset_err_count", 32'(mIf.err_count), 32'h0);
    d0 = donePulses;
    commitRow(0, 16'hA5C3);
    idle(LAT + 2);
    checkOutput("s1_model_cap0", 32'(mCap[0]), 32'hA5C3);
    checkOutput("s1_no_done", 32'(donePulses - d0), 32'd0);
    readRow(0, 16'h0000, "s1_disp_row0");

    // Scenario 2: full frame, rows 15..0.
    resetDut();
    d0 = donePulses;
    for (int k = ROWS - 1; k >= 0; k--) commitRow(k, COLS'(16'h0101 * k));
    idle(LAT + 2);
    checkOutput("s2_done_pulses", 32'(donePulses - d0), 32'd1);
    checkOutput("s2_frame_count", 32'(mIf.frame_count), 32'd1);
    readRow(7, 16'h0707, "s2_row7");

    // Scenario 3: bad row selects leave the partial frame intact.
    e0 = errPulses;
    d0 = donePulses;
    commitRow(3, 16'h3333);
    commitSel(16'h0003, 16'hDEAD);
    shiftRow(16'h0000);
    pulseOeb();
    idle(LAT + 2);
    checkOutput("s3_err_pulses", 32'(errPulses - e0), 32'd2);
    checkOutput("s3_err_count", 32'(mIf.err_count), 32'd2);
    for (int k = 0; k < ROWS; k++) begin
      if (k != 3) commitRow(k, COLS'(16'h1000 + k));
    end
    idle(LAT + 2);
    checkOutput("s3_done_pulses", 32'(donePulses - d0), 32'd1);
    checkOutput("s3_frame_count", 32'(mIf.frame_count), 32'd2);
    readRow(3, 16'h3333, "s3_row3");

    // Scenario 4: coincident cclk/le rises, then coincident le rise / oeb fall.
    resetDut();
    for (int k = 1; k < ROWS; k++) commitRow(k, COLS'(16'h1100 + k));
    shiftCol(16'hBEEF);
    applyStimulus(6'b100111);
    idle(LAT + 1);
    checkOutput("s4_model_collat", 32'(mColLat), 32'hBEEF);
    shiftRow(16'h0001);
    shiftCol(16'h1234);
    applyStimulus(6'b000100);
    idle(LAT + 2);
    checkOutput("s4_frame_count", 32'(mIf.frame_count), 32'd1);
    readRow(0, 16'hBEEF, "s4_row0_old_latch");
    readRow(5, 16'h1105, "s4_row5");

    // Scenario 5: reset mid-frame discards the partial frame.
    resetDut();
    for (int k = 0; k < 10; k++) commitRow(k, COLS'($urandom));
    resetDut();
    d0 = donePulses;
    for (int k = 0; k < ROWS; k++) begin
      commitRow(k, 16'hFFFF);
      if (k == ROWS - 2) checkOutput("s5_no_early_done", 32'(donePulses - d0), 32'd0);
    end
    idle(LAT + 2);
    checkOutput("s5_done_pulses", 32'(donePulses - d0), 32'd1);
    for (int k = 0; k < ROWS; k++) readRow(k, 16'hFFFF, "s5_row_ffff");

    // frame_count wraps: rotate the row one-hot and recommit the same latched columns.
    resetDut();
    shiftCol(16'h5A5A);
    pulseLe();
    shiftRow(16'h0001);
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < ROWS; k++) begin
        pulseOeb();
        rs = (k == ROWS - 1);
        applyStimulus({1'b1, rs, 1'b1, 3'b000});
        applyStimulus({1'b1, rs, 1'b0, 3'b000});
      end
      if (f == 254) begin
        idle(LAT + 1);
        checkOutput("wrap_count_255", 32'(mIf.frame_count), 32'd255);
      end
    end
    idle(LAT + 2);
    checkOutput("wrap_count_0", 32'(mIf.frame_count), 32'd0);
    readRow(9, 16'h5A5A, "wrap_row9");

    // err_count saturates at all-ones.
    resetDut();
    for (int k = 0; k < 260; k++) begin
      pulseOeb();
      if (k == 253) begin
        idle(LAT + 1);
        checkOutput("err_count_254", 32'(mIf.err_count), 32'd254);
      end
    end
    idle(LAT + 2);
    checkOutput("err_count_sat", 32'(mIf.err_count), 32'd255);

    // Randomised commits, random read addresses, then raw random pin activity.
    resetDut();
    randRd = 1'b1;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, ROWS - 1);
      sel = ($urandom_range(0, 7) == 0) ? ROWS'($urandom) : (ROWS'(1) << r);
      commitSel(sel, COLS'($urandom));
    end
    for (int k = 0; k < 3000; k++) applyStimulus(6'($urandom));
    idle(LAT + 2);
    randRd = 1'b0;
    checkEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
